// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
// Parses the ASCII byte stream from the UART receiver into one-cycle control
// pulses for the 0-9999 counter: R/S/C (run/stop/clear) and P<1-4 digits><CR|LF>
// (preset). The preset value is built digit by digit as it arrives. Malformed
// input, or silence while collecting digits, raises cmd_err and returns to idle.
module uart_cmd_decoder #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        cmd_run,
  output logic        cmd_stop,
  output logic        cmd_clear,
  output logic        cmd_preset,
  output logic [13:0] preset_val,
  output logic        cmd_err,
  output logic        parsing
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DIGIT = 1'b1
  } state_t;

  state_t        state;
  logic [13:0]   acc;
  logic [2:0]    dcnt;
  logic [TW-1:0] tcnt;

  // Byte classification. Clearing bit 5 folds lower-case letters onto
  // upper-case; only the two intended codes map onto each letter.
  logic [7:0]  folded;
  logic        is_digit;
  logic        is_eol;
  logic        is_space;
  logic [3:0]  digit_val;
  logic [16:0] acc_wide;
  logic [13:0] acc_next;

  assign folded    = rx_data & 8'hDF;
  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_eol    = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign is_space  = (rx_data == 8'h20);
  assign digit_val = rx_data[3:0];

  // acc*10 + digit, formed as shifts in 17 bits. At most four digits are
  // accepted, so the result never exceeds 9999 and the 14-bit truncation
  // loses nothing.
  assign acc_wide = {3'b000, acc};
  assign acc_next = 14'((acc_wide << 3) + (acc_wide << 1) + 17'(digit_val));

  // Parser state machine; every output is a flop so downstream sees clean pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      dcnt       <= '0;
      tcnt       <= '0;
      cmd_run    <= 1'b0;
      cmd_stop   <= 1'b0;
      cmd_clear  <= 1'b0;
      cmd_preset <= 1'b0;
      cmd_err    <= 1'b0;
      preset_val <= '0;
      parsing    <= 1'b0;
    end else begin
      cmd_run    <= 1'b0;
      cmd_stop   <= 1'b0;
      cmd_clear  <= 1'b0;
      cmd_preset <= 1'b0;
      cmd_err    <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_done) begin
            if (folded == 8'h52) begin
              cmd_run <= 1'b1;
            end else if (folded == 8'h53) begin
              cmd_stop <= 1'b1;
            end else if (folded == 8'h43) begin
              cmd_clear <= 1'b1;
            end else if (folded == 8'h50) begin
              acc     <= '0;
              dcnt    <= '0;
              tcnt    <= '0;
              state   <= DIGIT;
              parsing <= 1'b1;
            end else if (is_eol || is_space) begin
              // Line terminators and spaces between commands are harmless.
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end

        DIGIT: begin
          if (rx_done) begin
            // A byte always beats a coincident timeout expiry.
            tcnt <= '0;
            if (is_digit && (dcnt < 3'd4)) begin
              acc  <= acc_next;
              dcnt <= dcnt + 3'd1;
            end else if (is_eol && (dcnt != 3'd0)) begin
              preset_val <= acc;
              cmd_preset <= 1'b1;
              state      <= IDLE;
              parsing    <= 1'b0;
            end else begin
              // Fifth digit, empty preset, or any stray byte (a command
              // letter here is rejected, not executed).
              cmd_err <= 1'b1;
              state   <= IDLE;
              parsing <= 1'b0;
            end
          end else if (tcnt == T_LAST) begin
            cmd_err <= 1'b1;
            tcnt    <= '0;
            state   <= IDLE;
            parsing <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          parsing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Testbench for uart_cmd_decoder: directed test-plan sequences followed by a
// randomized byte stream, all checked cycle by cycle against a command-level
// reference model (digits kept in a queue, value computed arithmetically).
module tb_uart_cmd_decoder;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        cmd_run;
  logic        cmd_stop;
  logic        cmd_clear;
  logic        cmd_preset;
  logic [13:0] preset_val;
  logic        cmd_err;
  logic        parsing;

  uart_cmd_decoder #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .cmd_run    (cmd_run),
    .cmd_stop   (cmd_stop),
    .cmd_clear  (cmd_clear),
    .cmd_preset (cmd_preset),
    .preset_val (preset_val),
    .cmd_err    (cmd_err),
    .parsing    (parsing)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: are we collecting a preset, which digits so far,
  // how many silent cycles since the last byte, and the last loaded preset.
  bit          m_collect;
  int          m_digits[$];
  int          m_silent;
  logic [13:0] m_preset;

  function automatic logic [19:0] observed();
    return {cmd_run, cmd_stop, cmd_clear, cmd_preset, cmd_err, parsing, preset_val};
  endfunction

  task automatic model_reset();
    m_collect = 1'b0;
    m_digits.delete();
    m_silent  = 0;
    m_preset  = '0;
  endtask

  // Expected outputs one cycle after the given input cycle.
  task automatic model(input bit d, input logic [7:0] b, output logic [19:0] e);
    bit run, stop, clr, pre, err;
    logic [7:0] lc;
    int v;
    run = 0; stop = 0; clr = 0; pre = 0; err = 0;
    lc = (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
    if (!m_collect) begin
      if (d) begin
        if (lc == "r") run = 1;
        else if (lc == "s") stop = 1;
        else if (lc == "c") clr = 1;
        else if (lc == "p") begin
          m_collect = 1;
          m_digits.delete();
          m_silent = 0;
        end else if (b == 8'h0D || b == 8'h0A || b == 8'h20) begin
          // ignored
        end else err = 1;
      end
    end else if (d) begin
      m_silent = 0;
      if (b >= "0" && b <= "9") begin
        if (m_digits.size() == 4) begin
          err = 1;
          m_collect = 0;
        end else begin
          m_digits.push_back(int'(b) - 48);
        end
      end else if (b == 8'h0D || b == 8'h0A) begin
        if (m_digits.size() == 0) err = 1;
        else begin
          v = 0;
          foreach (m_digits[i]) v = v * 10 + m_digits[i];
          m_preset = 14'(v);
          pre = 1;
        end
        m_collect = 0;
      end else begin
        err = 1;
        m_collect = 0;
      end
    end else begin
      m_silent++;
      if (m_silent == TO) begin
        err = 1;
        m_collect = 0;
      end
    end
    e = {run, stop, clr, pre, err, m_collect, m_preset};
  endtask

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare after the edge.
  task automatic step(input bit d, input logic [7:0] b, input string tag);
    logic [19:0] e;
    rx_done = d;
    rx_data = d ? b : 8'($urandom);
    model(d, b, e);
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    check(tag, observed(), e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, "idle");
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(1'b1, b, $sformatf("byte_%02h", b));
    idle(gap);
  endtask

  task automatic check_preset(input string tag, input logic [13:0] want);
    check(tag, {6'd0, preset_val}, {6'd0, want});
  endtask

  initial begin
    logic [7:0] b;
    int sel;
    int gap;

    rst = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", observed(), 20'd0);
    rst = 1'b0;

    // Single-letter commands, widely spaced.
    send("r", 50);
    send("S", 50);
    send("c", 50);

    // Four-digit preset, then a one-digit preset with LF.
    send("P", 0); send("1", 0); send("2", 1); send("3", 0); send("4", 2);
    send(8'h0D, 0);
    check_preset("preset_1234", 14'd1234);
    idle(3);
    send("p", 1); send("7", 0); send(8'h0A, 0);
    check_preset("preset_7", 14'd7);
    idle(2);

    // Fifth digit overflow, recovery, and empty preset.
    send("p", 0);
    repeat (5) send("9", 0);
    send("r", 2);
    send("p", 0); send(8'h0D, 2);
    check_preset("empty_keeps_7", 14'd7);

    // Bad bytes, interrupted preset, and ignored separators.
    send("x", 1);
    send("p", 0); send("5", 0); send("s", 2);
    send(8'h0D, 0); send(8'h0A, 0); send(8'h20, 3);

    // Timeout expiry, then a byte landing exactly on the expiry cycle.
    send("p", 0); send("4", 20);
    send("p", 0); send("4", TO - 1); send("2", 0); send(8'h0D, 2);
    check_preset("preset_after_late_byte", 14'd42);

    // Asynchronous reset in the middle of a preset.
    send("p", 0); send("8", 0); send("8", 0);
    rst = 1'b1;
    model_reset();
    #1;
    check("async_reset_clears", observed(), 20'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send("1", 0); send(8'h0D, 3);

    // Randomized byte stream with short and occasionally timeout-length gaps.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 9: b = 8'(8'h30 + $urandom_range(0, 9));
        4:             b = ($urandom_range(0, 1) != 0) ? 8'h50 : 8'h70;
        5:             b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
        6: begin
          case ($urandom_range(0, 2))
            0:       b = 8'h52;
            1:       b = 8'h53;
            default: b = 8'h43;
          endcase
          if ($urandom_range(0, 1) != 0) b = b | 8'h20;
        end
        7:       b = 8'h20;
        default: b = 8'($urandom);
      endcase
      gap = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(TO - 3, TO + 2);
      send(b, gap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Downstream consumer of the UART receiver: takes each received byte (`rx_data` qualified by the one-cycle `rx_done` pulse) and parses an ASCII command stream into one-cycle control pulses for the 0–9999 counter. Supported commands: run, stop, clear, and a decimal preset (`P` followed by 1–4 digits and a line terminator). The preset digits are converted to binary on the fly. All outputs are registered; malformed input raises `cmd_err` and returns the parser to idle.

## Interface
- `TIMEOUT`, default 1_000_000 — clk cycles allowed between bytes while collecting preset digits; must be ≥ 2.
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `rx_data`  in  8  received byte; valid only in the cycle `rx_done` = 1
- `rx_done`  in  1  one-cycle byte-valid strobe from the receiver
- `cmd_run`  out  1  one-cycle pulse: start counting
- `cmd_stop`  out  1  one-cycle pulse: stop counting
- `cmd_clear`  out  1  one-cycle pulse: clear counter
- `cmd_preset`  out  1  one-cycle pulse: load `preset_val`
- `preset_val`  out  14  binary preset 0–9999; updated only together with `cmd_preset`, then held
- `cmd_err`  out  1  one-cycle pulse: bad byte, bad sequence or timeout
- `parsing`  out  1  high while in DIGIT state

## Operation
- States: IDLE, DIGIT. Internal: `acc` 14 b, `dcnt` 3 b, `tcnt` sized `$clog2(TIMEOUT+1)`.
- Bytes are processed only in cycles with `rx_done` = 1; `rx_data` is ignored otherwise.
- IDLE byte handling:
  - `R`/`r` (0x52/0x72) → `cmd_run`.
  - `S`/`s` → `cmd_stop`.
  - `C`/`c` → `cmd_clear`.
  - `P`/`p` → `acc` = 0, `dcnt` = 0, `tcnt` = 0, go to DIGIT.
  - CR (0x0D), LF (0x0A), space (0x20) → ignored, no pulse.
  - Any other byte → `cmd_err`.
- DIGIT byte handling:
  - `0`–`9` with `dcnt` < 4 → `acc` = acc·10 + (byte − 0x30), `dcnt`++.
    - Multiply as (acc<<3)+(acc<<1) in 17 b, truncated to 14 b. Four digits cannot exceed 9999, so truncation is lossless.
  - Digit with `dcnt` = 4 → `cmd_err`, go to IDLE.
  - CR or LF with `dcnt` ≥ 1 → `preset_val` ← `acc`, `cmd_preset`, go to IDLE.
  - CR or LF with `dcnt` = 0 → `cmd_err`, go to IDLE.
  - Any other byte, including a command letter → `cmd_err`, go to IDLE. The letter is not executed.
- Timeout, DIGIT only:
  - `tcnt` increments each cycle without `rx_done` and clears on `rx_done`.
  - When `tcnt` reaches TIMEOUT−1 with no `rx_done` → `cmd_err`, go to IDLE.
  - Simultaneous `rx_done` and expiry: the byte wins. It is processed normally and `tcnt` clears.
- At most one output pulse per byte. Pulses never overlap.

## Timing
- Reset values: all pulses 0, `preset_val` 0, `parsing` 0, state IDLE, `acc`/`dcnt`/`tcnt` 0.
- Latency: the pulse for a byte whose `rx_done` is high in cycle n is high in cycle n+1 only.
- `preset_val` changes on the same edge that raises `cmd_preset`.
- `parsing` rises in cycle n+1 after the `P` byte. It falls in the cycle the terminating pulse (`cmd_preset`/`cmd_err`) is high.
- Back-to-back `rx_done` in consecutive cycles must be handled; each byte is fully processed in its own cycle.
- Reset mid-DIGIT: partial preset is discarded, `preset_val` returns to 0, and no pulse is emitted.

## Test plan
- Reset, then bytes `r`, `S`, `c` spaced 50 cycles apart → `cmd_run`, `cmd_stop`, `cmd_clear` each high exactly 1 cycle, one cycle after their `rx_done`; no `cmd_err`.
- `P`,`1`,`2`,`3`,`4`,CR → `cmd_preset` pulse with `preset_val` = 1234 (0x04D2); `parsing` high from after `P` until the pulse; then `p`,`7`,LF → `preset_val` = 7.
- `p`,`9`,`9`,`9`,`9`,`9` → `cmd_err` on the 5th digit, IDLE; following `r` → `cmd_run`. Also `p`,CR → `cmd_err`, `preset_val` unchanged.
- `x` in IDLE → `cmd_err`; `p`,`5`,`s` → `cmd_err` and no `cmd_stop`; CR/LF/space in IDLE → no pulses.
- TIMEOUT = 16: `p`,`4` then silence → `cmd_err` exactly when `tcnt` reaches 15, `parsing` drops. Then repeat with a byte arriving on the expiry cycle → no `cmd_err`; the byte is processed.
- Assert `rst` mid-preset after `p`,`8`,`8` → all outputs 0 immediately. After release, `1`,CR → `cmd_err` for the unexpected `1` in IDLE; CR is ignored.
